match_sequencer: RTL and testbench
==================================

# match_sequencer

Match-level controller for the ball datapath. Sequences an air-hockey match through idle, serve countdown, live play, post-goal pause and game over. Owns both player scores and holds the ball datapath at centre court whenever play is not live. Sits between the goal-detect pulses from the ball controller, the start button and the frame-rate tick from the VGA timing chain.

## Interface

Parameters:
- WIN_SCORE, 7: score that ends the match (1..15).
- SERVE_FRAMES, 60: frame ticks of serve countdown before release (1..255).
- GOAL_FRAMES, 90: frame ticks of post-goal pause (1..255).

Ports:
- clk_in, input, 1: system clock.
- rst_n, input, 1: asynchronous, active-low reset.
- frame_tick, input, 1: one-cycle pulse per video frame.
- start, input, 1: start button level, already synchronised to clk_in.
- goal_p1, input, 1: one-cycle pulse, ball entered the right goal (point to player 1).
- goal_p2, input, 1: one-cycle pulse, ball entered the left goal (point to player 2).
- ball_hold, output, 1: 1 forces the ball datapath to centre (487,362) with zero speed.
- serve_dir, output, 1: 0 = serve toward player 1 (left), 1 = toward player 2 (right). Valid when ball_hold falls.
- player_1_score, output, 4: player 1 score.
- player_2_score, output, 4: player 2 score.
- winner, output, 2: 0 none, 1 player 1, 2 player 2.
- game_state, output, 3: current state encoding.
- countdown, output, 8: remaining frame ticks in SERVE or PAUSE, 0 otherwise.

## Operation

- States: IDLE=0, SERVE=1, PLAY=2, PAUSE=3, OVER=4. Any other code returns to IDLE on the next clock.
- Start edge: start_q is registered, and start_rise = start & ~start_q. A held button counts once.
- IDLE: ball_hold=1. On start_rise, clear the scores, set winner=0 and serve_dir=0, then go to SERVE.
- SERVE: ball_hold=1. countdown loads SERVE_FRAMES-1 on entry. On each frame_tick, if countdown==0 go to PLAY, else decrement.
- PLAY: ball_hold=0. goal_p1 alone increments player_1_score and sets serve_dir=1 (the conceding player receives). goal_p2 alone increments player_2_score and sets serve_dir=0. Either case goes to PAUSE.
- Simultaneous goal_p1 and goal_p2 in PLAY: no score change, serve_dir unchanged, go to PAUSE (replay).
- PAUSE: ball_hold=1. countdown loads GOAL_FRAMES-1 on entry. When the countdown expires (same rule as SERVE), check the scores:
  - if either score equals WIN_SCORE, go to OVER;
  - else go to SERVE.
- OVER: ball_hold=1. winner is set to the player at WIN_SCORE. On start_rise, clear the scores and winner, then go to SERVE.
- Goal pulses outside PLAY are ignored. start_rise outside IDLE and OVER is ignored.
- Scores never exceed WIN_SCORE. Increment logic saturates at WIN_SCORE, and scores are 4-bit unsigned.
- A frame_tick in the same cycle as state entry does not decrement. The counter load has priority.

## Timing

- Reset (async assert, sync release) values:
  - state = IDLE;
  - ball_hold = 1;
  - serve_dir = 0;
  - both scores = 0;
  - winner = 0;
  - countdown = 0;
  - start_q = 0.
- All outputs are registered and driven directly from flops.
- A goal pulse in cycle n produces, in cycle n+1: the updated score, game_state=PAUSE, ball_hold=1 and countdown=GOAL_FRAMES-1.
- SERVE lasts exactly SERVE_FRAMES frame_ticks. The cycle after the SERVE_FRAMES-th tick shows game_state=PLAY and ball_hold=0.
- A start rising edge in cycle n gives game_state=SERVE in cycle n+2: one cycle for edge detect, one for the state register.
- Reset asserted mid-match forces the IDLE values immediately, without waiting for a clock edge.

## Structure

- Shared package air_hockey_pkg holds:
  - state encodings STATE_IDLE..STATE_OVER;
  - winner codes WIN_NONE, WIN_P1, WIN_P2;
  - CENTRE_X=487 and CENTRE_Y=362, which the ball datapath also uses.
- Sub-module frame_countdown: 8-bit down-counter with load, load_val, tick, zero outputs, same clk_in/rst_n.
- Top: FSM, score registers, edge detect.

## Test plan

- Reset, then start pulse: game_state goes 0→1 two cycles after the edge, countdown=59, ball_hold=1. After 60 frame_ticks, game_state=2 and ball_hold=0.
- In PLAY, goal_p1 pulse: player_1_score 0→1, serve_dir=1 and game_state=3 next cycle. After 90 ticks, game_state=1.
- In PLAY, goal_p1 and goal_p2 in the same cycle: scores unchanged, game_state=3, serve_dir unchanged.
- With player_2_score=6, goal_p2 gives 7. After the pause, game_state=4 and winner=2. A further goal_p1 pulse leaves player_1_score unchanged.
- In OVER, start held high for 100 cycles gives one restart: scores=0, winner=0, game_state=1. Goal pulses during SERVE are ignored.
- Assert rst_n low mid-PAUSE between clock edges: all outputs take their reset values asynchronously. Release, then start works normally.

Source files
------------

// File: rtl/air_hockey_pkg.sv
// air_hockey_pkg: shared state codes, winner codes and court geometry for the air-hockey blocks.
package air_hockey_pkg;

    typedef enum logic [2:0] {
        STATE_IDLE  = 3'd0,
        STATE_SERVE = 3'd1,
        STATE_PLAY  = 3'd2,
        STATE_PAUSE = 3'd3,
        STATE_OVER  = 3'd4
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;

    localparam int CENTRE_X = 487;
    localparam int CENTRE_Y = 362;

    function automatic logic [3:0] sat_inc(input logic [3:0] s, input logic [3:0] lim);
        return (s >= lim) ? lim : s + 4'd1;
    endfunction

endpackage

// File: rtl/frame_countdown.sv
// frame_countdown: 8-bit frame-tick down-counter; a load always wins over a tick.
module frame_countdown (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       tick,
    output logic [7:0] count,
    output logic       zero
);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n)
            count <= 8'd0;
        else
            count <= load ? load_val : (tick && count != 8'd0) ? count - 8'd1 : count;
    end

    assign zero = (count == 8'd0);

endmodule

// File: rtl/match_sequencer.sv
// match_sequencer: match FSM, score keeping and start-edge detection for the air-hockey game.
module match_sequencer
    import air_hockey_pkg::*;
#(
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60,
    parameter int GOAL_FRAMES  = 90
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       goal_p1,
    input  logic       goal_p2,
    output logic       ball_hold,
    output logic       serve_dir,
    output logic [3:0] player_1_score,
    output logic [3:0] player_2_score,
    output logic [1:0] winner,
    output logic [2:0] game_state,
    output logic [7:0] countdown
);

    localparam logic [3:0] WIN = 4'(WIN_SCORE);

    state_t     state, nxt;
    logic       start_q, start_rise;
    logic [3:0] p1_n, p2_n;
    logic       dir_n;
    logic [1:0] win_n;
    logic       load, zero, expire;
    logic [7:0] load_val;

    frame_countdown u_countdown (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val),
        .tick     (frame_tick),
        .count    (countdown),
        .zero     (zero)
    );

    assign expire     = frame_tick & zero;
    assign game_state = state;

    always_comb begin
        nxt   = state;
        p1_n  = player_1_score;
        p2_n  = player_2_score;
        dir_n = serve_dir;
        win_n = winner;
        case (state)
            STATE_IDLE: if (start_rise) begin
                nxt   = STATE_SERVE;
                p1_n  = 4'd0;
                p2_n  = 4'd0;
                win_n = WIN_NONE;
                dir_n = 1'b0;
            end
            STATE_SERVE: if (expire) nxt = STATE_PLAY;
            STATE_PLAY: begin
                // the conceding player receives the next serve; a double goal is a replay
                if (goal_p1 && !goal_p2) begin
                    p1_n  = sat_inc(player_1_score, WIN);
                    dir_n = 1'b1;
                end else if (goal_p2 && !goal_p1) begin
                    p2_n  = sat_inc(player_2_score, WIN);
                    dir_n = 1'b0;
                end
                if (goal_p1 || goal_p2) nxt = STATE_PAUSE;
            end
            STATE_PAUSE: if (expire) begin
                nxt   = (player_1_score == WIN || player_2_score == WIN) ? STATE_OVER : STATE_SERVE;
                win_n = (player_1_score == WIN) ? WIN_P1 : (player_2_score == WIN) ? WIN_P2 : winner;
            end
            STATE_OVER: if (start_rise) begin
                nxt   = STATE_SERVE;
                p1_n  = 4'd0;
                p2_n  = 4'd0;
                win_n = WIN_NONE;
            end
            default: nxt = STATE_IDLE;
        endcase
        load     = (nxt != state);
        load_val = (nxt == STATE_SERVE) ? 8'(SERVE_FRAMES - 1) :
                   (nxt == STATE_PAUSE) ? 8'(GOAL_FRAMES - 1) : 8'd0;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state          <= STATE_IDLE;
            start_q        <= 1'b0;
            start_rise     <= 1'b0;
            ball_hold      <= 1'b1;
            serve_dir      <= 1'b0;
            player_1_score <= 4'd0;
            player_2_score <= 4'd0;
            winner         <= WIN_NONE;
        end else begin
            state          <= nxt;
            start_q        <= start;
            start_rise     <= start & ~start_q;
            ball_hold      <= (nxt != STATE_PLAY);
            serve_dir      <= dir_n;
            player_1_score <= p1_n;
            player_2_score <= p2_n;
            winner         <= win_n;
        end
    end

endmodule

// File: tb/tb_match_sequencer.sv
// tb_match_sequencer: directed scenario tasks plus a randomized run checked against a behavioural match model.
module tb_match_sequencer;

    localparam int WS = 7;
    localparam int SF = 60;
    localparam int GF = 90;

    logic       clk_in = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic       goal_p1 = 1'b0;
    logic       goal_p2 = 1'b0;
    logic       ball_hold, serve_dir;
    logic [3:0] player_1_score, player_2_score;
    logic [1:0] winner;
    logic [2:0] game_state;
    logic [7:0] countdown;

    int n_cmp = 0;
    int n_bad = 0;

    match_sequencer #(.WIN_SCORE(WS), .SERVE_FRAMES(SF), .GOAL_FRAMES(GF)) dut (
        .clk_in         (clk_in),
        .rst_n          (rst_n),
        .frame_tick     (frame_tick),
        .start          (start),
        .goal_p1        (goal_p1),
        .goal_p2        (goal_p2),
        .ball_hold      (ball_hold),
        .serve_dir      (serve_dir),
        .player_1_score (player_1_score),
        .player_2_score (player_2_score),
        .winner         (winner),
        .game_state     (game_state),
        .countdown      (countdown)
    );

    always #5 clk_in = ~clk_in;

    // Reference model: phase 0 idle, 1 serve, 2 play, 3 pause, 4 over; m_left = frame ticks still needed to leave
    int m_phase = 0, m_left = 0, m_s1 = 0, m_s2 = 0, m_dir = 0, m_win = 0;
    bit m_prev = 0, m_rise = 0;

    always @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_left = 0; m_s1 = 0; m_s2 = 0; m_dir = 0; m_win = 0;
            m_prev = 0; m_rise = 0;
        end else begin
            bit rise;
            rise   = m_rise;
            m_rise = start && !m_prev;
            m_prev = start;
            if (m_phase == 0 || m_phase == 4) begin
                if (rise) begin
                    m_s1 = 0; m_s2 = 0; m_win = 0;
                    if (m_phase == 0) m_dir = 0;
                    m_phase = 1; m_left = SF;
                end
            end else if (m_phase == 1) begin
                if (frame_tick) begin
                    m_left--;
                    if (m_left == 0) m_phase = 2;
                end
            end else if (m_phase == 2) begin
                if (goal_p1 && !goal_p2) begin
                    m_s1 = (m_s1 + 1 > WS) ? WS : m_s1 + 1; m_dir = 1;
                end else if (goal_p2 && !goal_p1) begin
                    m_s2 = (m_s2 + 1 > WS) ? WS : m_s2 + 1; m_dir = 0;
                end
                if (goal_p1 || goal_p2) begin
                    m_phase = 3; m_left = GF;
                end
            end else if (m_phase == 3) begin
                if (frame_tick) begin
                    m_left--;
                    if (m_left == 0) begin
                        if (m_s1 == WS || m_s2 == WS) begin
                            m_phase = 4; m_win = (m_s1 == WS) ? 1 : 2;
                        end else begin
                            m_phase = 1; m_left = SF;
                        end
                    end
                end
            end
        end
    end

    // Stimulus only: score one goal from PLAY and tick through pause (and serve when the match continues)
    task automatic play_point(input logic a, input logic b, input bit back_to_play);
        goal_p1 = a; goal_p2 = b;
        @(negedge clk_in);
        goal_p1 = 0; goal_p2 = 0; frame_tick = 1;
        repeat (back_to_play ? GF + SF : GF) @(negedge clk_in);
        frame_tick = 0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk_in);
        n_cmp++;
        if ({game_state, ball_hold, serve_dir, player_1_score, player_2_score, winner, countdown} !==
            {3'd0, 1'b1, 1'b0, 4'd0, 4'd0, 2'd0, 8'd0}) begin
            n_bad++;
            $display("FAIL reset_values: state=%0d hold=%0d dir=%0d s1=%0d s2=%0d win=%0d cd=%0d, want 0 1 0 0 0 0 0",
                     game_state, ball_hold, serve_dir, player_1_score, player_2_score, winner, countdown);
        end
        rst_n = 1;
        @(negedge clk_in);
    endtask

    task automatic test_serve;
        start = 1;
        @(negedge clk_in);
        n_cmp++;
        if (game_state !== 3'd0) begin n_bad++; $display("FAIL serve_edge_latency1: state=%0d want 0", game_state); end
        @(negedge clk_in);
        start = 0; frame_tick = 1;
        n_cmp++;
        if ({game_state, countdown, ball_hold} !== {3'd1, 8'd59, 1'b1}) begin
            n_bad++;
            $display("FAIL serve_entry: state=%0d cd=%0d hold=%0d want 1 59 1", game_state, countdown, ball_hold);
        end
        repeat (SF - 1) @(negedge clk_in);
        n_cmp++;
        if ({game_state, countdown} !== {3'd1, 8'd0}) begin
            n_bad++; $display("FAIL serve_last_tick: state=%0d cd=%0d want 1 0", game_state, countdown);
        end
        @(negedge clk_in);
        frame_tick = 0;
        n_cmp++;
        if ({game_state, ball_hold, countdown} !== {3'd2, 1'b0, 8'd0}) begin
            n_bad++; $display("FAIL serve_release: state=%0d hold=%0d cd=%0d want 2 0 0", game_state, ball_hold, countdown);
        end
    endtask

    task automatic test_goal;
        goal_p1 = 1;
        @(negedge clk_in);
        goal_p1 = 0; frame_tick = 1;
        n_cmp++;
        if ({player_1_score, player_2_score, serve_dir, game_state, ball_hold, countdown} !==
            {4'd1, 4'd0, 1'b1, 3'd3, 1'b1, 8'd89}) begin
            n_bad++;
            $display("FAIL goal_p1: s1=%0d s2=%0d dir=%0d state=%0d hold=%0d cd=%0d want 1 0 1 3 1 89",
                     player_1_score, player_2_score, serve_dir, game_state, ball_hold, countdown);
        end
        repeat (GF) @(negedge clk_in);
        n_cmp++;
        if ({game_state, countdown, serve_dir} !== {3'd1, 8'd59, 1'b1}) begin
            n_bad++; $display("FAIL pause_to_serve: state=%0d cd=%0d dir=%0d want 1 59 1", game_state, countdown, serve_dir);
        end
        repeat (SF) @(negedge clk_in);
        frame_tick = 0;
    endtask

    task automatic test_double_goal;
        goal_p1 = 1; goal_p2 = 1;
        @(negedge clk_in);
        goal_p1 = 0; goal_p2 = 0;
        n_cmp++;
        if ({player_1_score, player_2_score, serve_dir, game_state} !== {4'd1, 4'd0, 1'b1, 3'd3}) begin
            n_bad++;
            $display("FAIL double_goal: s1=%0d s2=%0d dir=%0d state=%0d want 1 0 1 3",
                     player_1_score, player_2_score, serve_dir, game_state);
        end
        frame_tick = 1;
        repeat (GF + SF) @(negedge clk_in);
        frame_tick = 0;
        n_cmp++;
        if (game_state !== 3'd2) begin n_bad++; $display("FAIL replay_to_play: state=%0d want 2", game_state); end
    endtask

    task automatic test_win;
        repeat (WS - 1) play_point(1'b0, 1'b1, 1'b1);
        n_cmp++;
        if ({player_2_score, game_state, serve_dir} !== {4'd6, 3'd2, 1'b0}) begin
            n_bad++; $display("FAIL six_points: s2=%0d state=%0d dir=%0d want 6 2 0", player_2_score, game_state, serve_dir);
        end
        goal_p2 = 1;
        @(negedge clk_in);
        goal_p2 = 0;
        n_cmp++;
        if ({player_2_score, game_state, winner} !== {4'd7, 3'd3, 2'd0}) begin
            n_bad++; $display("FAIL winning_goal: s2=%0d state=%0d win=%0d want 7 3 0", player_2_score, game_state, winner);
        end
        frame_tick = 1;
        repeat (GF) @(negedge clk_in);
        frame_tick = 0;
        n_cmp++;
        if ({game_state, winner, ball_hold, countdown} !== {3'd4, 2'd2, 1'b1, 8'd0}) begin
            n_bad++;
            $display("FAIL game_over: state=%0d win=%0d hold=%0d cd=%0d want 4 2 1 0", game_state, winner, ball_hold, countdown);
        end
        goal_p1 = 1;
        @(negedge clk_in);
        goal_p1 = 0;
        @(negedge clk_in);
        n_cmp++;
        if ({player_1_score, game_state} !== {4'd1, 3'd4}) begin
            n_bad++; $display("FAIL goal_in_over: s1=%0d state=%0d want 1 4", player_1_score, game_state);
        end
    endtask

    task automatic test_restart;
        start = 1;
        repeat (100) @(negedge clk_in);
        n_cmp++;
        if ({player_1_score, player_2_score, winner, game_state, countdown} !== {4'd0, 4'd0, 2'd0, 3'd1, 8'd59}) begin
            n_bad++;
            $display("FAIL held_start_restart: s1=%0d s2=%0d win=%0d state=%0d cd=%0d want 0 0 0 1 59",
                     player_1_score, player_2_score, winner, game_state, countdown);
        end
        start = 0;
        goal_p1 = 1;
        @(negedge clk_in);
        goal_p1 = 0; goal_p2 = 1;
        @(negedge clk_in);
        goal_p2 = 0;
        @(negedge clk_in);
        n_cmp++;
        if ({player_1_score, player_2_score, game_state} !== {4'd0, 4'd0, 3'd1}) begin
            n_bad++; $display("FAIL goal_in_serve: s1=%0d s2=%0d state=%0d want 0 0 1", player_1_score, player_2_score, game_state);
        end
    endtask

    task automatic test_async_reset;
        frame_tick = 1;
        repeat (SF) @(negedge clk_in);
        frame_tick = 0;
        play_point(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (game_state !== 3'd1) begin n_bad++; $display("FAIL pre_reset_serve: state=%0d want 1", game_state); end
        frame_tick = 1;
        repeat (SF) @(negedge clk_in);
        frame_tick = 0;
        goal_p1 = 1;
        @(negedge clk_in);
        goal_p1 = 0;
        #2 rst_n = 0;
        #1;
        n_cmp++;
        if ({game_state, ball_hold, serve_dir, player_1_score, player_2_score, winner, countdown} !==
            {3'd0, 1'b1, 1'b0, 4'd0, 4'd0, 2'd0, 8'd0}) begin
            n_bad++;
            $display("FAIL async_reset: state=%0d hold=%0d dir=%0d s1=%0d s2=%0d win=%0d cd=%0d, want 0 1 0 0 0 0 0",
                     game_state, ball_hold, serve_dir, player_1_score, player_2_score, winner, countdown);
        end
        @(negedge clk_in);
        rst_n = 1;
        @(negedge clk_in);
        start = 1;
        repeat (2) @(negedge clk_in);
        start = 0;
        n_cmp++;
        if ({game_state, countdown} !== {3'd1, 8'd59}) begin
            n_bad++; $display("FAIL start_after_reset: state=%0d cd=%0d want 1 59", game_state, countdown);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 8000; i++) begin
            int exp_cd;
            @(negedge clk_in);
            exp_cd = (m_phase == 1 || m_phase == 3) ? m_left - 1 : 0;
            n_cmp++;
            if ({game_state, ball_hold, serve_dir, player_1_score, player_2_score, winner, countdown} !==
                {3'(m_phase), m_phase != 2, 1'(m_dir), 4'(m_s1), 4'(m_s2), 2'(m_win), 8'(exp_cd)}) begin
                n_bad++;
                $display("FAIL random_cycle_%0d: state=%0d hold=%0d dir=%0d s1=%0d s2=%0d win=%0d cd=%0d, want %0d %0d %0d %0d %0d %0d %0d",
                         i, game_state, ball_hold, serve_dir, player_1_score, player_2_score, winner, countdown,
                         m_phase, m_phase != 2, m_dir, m_s1, m_s2, m_win, exp_cd);
            end
            frame_tick = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 30) == 0) start = ~start;
            goal_p1 = ($urandom_range(0, 15) == 0);
            goal_p2 = ($urandom_range(0, 15) == 0);
        end
        frame_tick = 0; goal_p1 = 0; goal_p2 = 0; start = 0;
    endtask

    initial begin
        test_reset();
        test_serve();
        test_goal();
        test_double_goal();
        test_win();
        test_restart();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
